// File: rtl/ifu_fetch.sv
// Instruction fetch stage: architectural PC, single-outstanding imem request FSM
// and a small registered {inst, pc} FIFO toward decode; a redirect flushes both.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t         state, state_nx;
   logic [31:0]    pc, pc_nx;
   logic [CW-1:0]  count, count_nx;
   logic [AW-1:0]  rd_ptr, rd_ptr_nx;
   logic [AW-1:0]  wr_ptr, wr_ptr_nx;
   logic [31:0]    data_mem [DEPTH];
   logic [31:0]    pc_mem   [DEPTH];
   logic           req_valid_nx;
   logic           handshake;
   logic           push;
   logic           pop;
   logic           unused_bits;

   assign handshake     = imem_req_valid & imem_req_ready;
   assign pop           = inst_valid & inst_ready;
   assign imem_req_addr = pc;
   assign inst_valid    = (count != '0);
   assign inst          = data_mem[rd_ptr];
   assign inst_pc       = pc_mem[rd_ptr];
   assign unused_bits   = ^redirect_pc[1:0];

   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      state_nx = state;
      pc_nx    = pc;
      push     = 1'b0;

      case (state)
         IDLE: state_nx = REQ;
         REQ:  if (handshake) state_nx = WAIT;
         WAIT: begin
            if (imem_rsp_valid) begin
               push     = 1'b1;
               pc_nx    = pc + 32'd4;
               state_nx = REQ;
            end
         end
         DROP: if (imem_rsp_valid) state_nx = REQ;
         default: state_nx = IDLE;
      endcase

      // A redirect wins over everything; a request already accepted must drain through DROP.
      if (redirect_valid) begin
         push  = 1'b0;
         pc_nx = {redirect_pc[31:2], 2'b00};
         case (state)
            REQ:     state_nx = handshake ? DROP : REQ;
            WAIT:    state_nx = imem_rsp_valid ? REQ : DROP;
            DROP:    state_nx = imem_rsp_valid ? REQ : DROP;
            default: state_nx = REQ;
         endcase
      end

      rd_ptr_nx = rd_ptr;
      wr_ptr_nx = wr_ptr;
      if (redirect_valid) begin
         count_nx  = '0;
         rd_ptr_nx = '0;
         wr_ptr_nx = '0;
      end else begin
         count_nx = count + CW'(push) - CW'(pop);
         if (push) wr_ptr_nx = wr_ptr + AW'(1);
         if (pop)  rd_ptr_nx = rd_ptr + AW'(1);
      end

      // Registered request valid: with nothing in flight in REQ, issue needs a free slot.
      req_valid_nx = (state_nx == REQ) && (count_nx < CW'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         count          <= '0;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         imem_req_valid <= 1'b0;
         // NOTE: the tiny FIFO storage is reset so inst/inst_pc read zero out of reset.
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else begin
         state          <= state_nx;
         pc             <= pc_nx;
         count          <= count_nx;
         rd_ptr         <= rd_ptr_nx;
         wr_ptr         <= wr_ptr_nx;
         imem_req_valid <= req_valid_nx;
         if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= pc;
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: memory responder with configurable ready/latency, and a
// stream model (sequential PCs restarting at reset/redirect targets) plus directed scenarios.
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int          errors = 0;
   int          checks = 0;
   int          ready_mode = 2;     // 0: always ready, 1: random, 2: never
   int          lat_cfg = 1;        // response latency in cycles; 0 picks 1..4 at random
   int          pops = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] acc_q[$];
   logic [31:0] pop_q[$];

   ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h8000_0013;
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   // Instruction memory: one response per accepted request, in order, after lat cycles.
   initial begin : responder
      bit          pend;
      int          cnt;
      logic [31:0] paddr;
      pend = 1'b0;
      cnt = 0;
      paddr = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         #1;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         if (!rst_n) pend = 1'b0;
         else if (pend) begin
            if (cnt == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(paddr);
               pend = 1'b0;
            end else cnt--;
         end
         case (ready_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = 1'($urandom_range(0, 1));
            default: imem_req_ready = 1'b0;
         endcase
         if (rst_n && imem_req_valid) begin
            checks++;
            if (pend || imem_rsp_valid) begin
               errors++;
               $display("FAIL single_inflight: request valid at %h with a request still outstanding, required none", imem_req_addr);
            end
            if (imem_req_ready) begin
               pend  = 1'b1;
               paddr = imem_req_addr;
               cnt   = (lat_cfg == 0) ? int'($urandom_range(0, 3)) : lat_cfg - 1;
               acc_q.push_back(imem_req_addr);
            end
         end
      end
   end

   // Stream model: delivered PCs run sequentially from the last reset or redirect target.
   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) exp_pc = RESET_PC;
         else begin
            if (imem_req_valid) begin
               checks++;
               if (imem_req_addr[1:0] !== 2'b00) begin
                  errors++;
                  $display("FAIL addr_align: addr %h, required low bits 00", imem_req_addr);
               end
            end
            if (inst_valid && inst_ready) begin
               checks++;
               if (inst_pc !== exp_pc) begin
                  errors++;
                  $display("FAIL stream_pc: inst_pc %h, required %h", inst_pc, exp_pc);
               end
               checks++;
               if (inst !== mem_word(inst_pc)) begin
                  errors++;
                  $display("FAIL stream_data: inst %h at pc %h, required %h", inst, inst_pc, mem_word(inst_pc));
               end
               pop_q.push_back(inst_pc);
               pops++;
               exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      inst_ready = 1'b0;
      ready_mode = 2;
      lat_cfg = 1;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      acc_q.delete();
      pop_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      inst_ready = 1'b0;
      ready_mode = 2;
      tick(2);
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid); end
      checks++;
      if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b, required 0", inst_valid); end
      checks++;
      if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h, required 00000000", inst); end
      checks++;
      if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h, required 00000000", inst_pc); end
      rst_n = 1'b1;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid: got %b, required 0", imem_req_valid); end
      tick(1);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         errors++;
         $display("FAIL first_request: valid %b addr %h, required 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
      end
      acc_q.delete();
      pop_q.delete();
   endtask

   task automatic test_first_fetch();
      int n;
      ready_mode = 0;
      lat_cfg = 1;
      inst_ready = 1'b0;
      n = 0;
      while (inst_valid !== 1'b1 && n < 20) begin tick(1); n++; end
      checks++;
      if (inst_valid !== 1'b1) begin errors++; $display("FAIL first_inst_timeout: inst_valid %b, required 1", inst_valid); end
      checks++;
      if (inst !== 32'h0000_0013) begin errors++; $display("FAIL first_inst: got %h, required 00000013", inst); end
      checks++;
      if (inst_pc !== RESET_PC) begin errors++; $display("FAIL first_inst_pc: got %h, required %h", inst_pc, RESET_PC); end
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
         errors++;
         $display("FAIL next_request: valid %b addr %h, required 1 80000004", imem_req_valid, imem_req_addr);
      end
      checks++;
      if (acc_q.size() < 1 || acc_q[0] !== RESET_PC) begin errors++; $display("FAIL first_accept_addr: accepts %0d, required first at %h", acc_q.size(), RESET_PC); end
   endtask

   task automatic test_fifo_full();
      do_reset();
      ready_mode = 0;
      lat_cfg = 1;
      tick(12);
      checks++;
      if (acc_q.size() != 2) begin errors++; $display("FAIL full_accepts: got %0d, required 2", acc_q.size()); end
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL full_req_valid: got %b, required 0", imem_req_valid); end
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin
         errors++;
         $display("FAIL full_head: valid %b pc %h, required 1 %h", inst_valid, inst_pc, RESET_PC);
      end
      inst_ready = 1'b1;
      tick(8);
      checks++;
      if (pop_q.size() < 2 || pop_q[0] !== RESET_PC || pop_q[1] !== 32'h8000_0004) begin
         errors++;
         $display("FAIL full_drain_order: pops %0d, required 80000000 then 80000004", pop_q.size());
      end
      checks++;
      if (acc_q.size() < 3 || acc_q[2] !== 32'h8000_0008) begin errors++; $display("FAIL full_resume: accepts %0d, required third at 80000008", acc_q.size()); end
   endtask

   task automatic test_back_to_back();
      int p0;
      do_reset();
      ready_mode = 0;
      lat_cfg = 1;
      inst_ready = 1'b1;
      tick(10);
      p0 = pops;
      tick(20);
      checks++;
      if (pops - p0 != 10) begin errors++; $display("FAIL throughput: %0d pops in 20 cycles, required 10", pops - p0); end
   endtask

   task automatic test_redirect_wait();
      int n;
      do_reset();
      ready_mode = 0;
      lat_cfg = 5;
      inst_ready = 1'b1;
      n = 0;
      while (acc_q.size() == 0 && n < 20) begin tick(1); n++; end
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_1002;
      lat_cfg = 1;
      tick(1);
      redirect_valid = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drop_req_valid: got %b, required 0", imem_req_valid); end
      n = 0;
      while (acc_q.size() < 2 && n < 20) begin
         checks++;
         if (inst_valid !== 1'b0) begin errors++; $display("FAIL stale_inst_valid: got %b, required 0", inst_valid); end
         tick(1);
         n++;
      end
      checks++;
      if (acc_q.size() < 2 || acc_q[1] !== 32'h8000_1000) begin errors++; $display("FAIL redirect_wait_addr: accepts %0d, required second at 80001000", acc_q.size()); end
      n = 0;
      while (pop_q.size() == 0 && n < 20) begin tick(1); n++; end
      checks++;
      if (pop_q.size() == 0 || pop_q[0] !== 32'h8000_1000) begin errors++; $display("FAIL redirect_wait_pop: pops %0d, required first at 80001000", pop_q.size()); end
   endtask

   task automatic test_redirect_handshake();
      int n;
      do_reset();
      lat_cfg = 2;
      inst_ready = 1'b1;
      checks++;
      if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL hs_pre_valid: got %b, required 1", imem_req_valid); end
      ready_mode = 0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_2000;
      tick(1);
      redirect_valid = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL hs_drop_valid: got %b, required 0", imem_req_valid); end
      n = 0;
      while (acc_q.size() < 2 && n < 20) begin tick(1); n++; end
      checks++;
      if (acc_q.size() < 2 || acc_q[0] !== RESET_PC || acc_q[1] !== 32'h8000_2000) begin
         errors++;
         $display("FAIL hs_accepts: accepts %0d, required 80000000 then 80002000", acc_q.size());
      end
      n = 0;
      while (pop_q.size() == 0 && n < 20) begin tick(1); n++; end
      checks++;
      if (pop_q.size() == 0 || pop_q[0] !== 32'h8000_2000) begin errors++; $display("FAIL hs_pop: pops %0d, required first at 80002000", pop_q.size()); end
   endtask

   task automatic test_stall_wrap();
      int n;
      do_reset();
      inst_ready = 1'b1;
      lat_cfg = 1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      tick(1);
      redirect_valid = 1'b0;
      repeat (5) begin
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL stall_hold: valid %b addr %h, required 1 fffffffc", imem_req_valid, imem_req_addr);
         end
         tick(1);
      end
      ready_mode = 0;
      n = 0;
      while (acc_q.size() < 2 && n < 20) begin tick(1); n++; end
      checks++;
      if (acc_q.size() < 2 || acc_q[0] !== 32'hFFFF_FFFC || acc_q[1] !== 32'h0000_0000) begin
         errors++;
         $display("FAIL wrap_accepts: accepts %0d, required fffffffc then 00000000", acc_q.size());
      end
      n = 0;
      while (pop_q.size() < 2 && n < 20) begin tick(1); n++; end
      checks++;
      if (pop_q.size() < 2 || pop_q[1] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pop: pops %0d, required second at 00000000", pop_q.size()); end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      ready_mode = 0;
      lat_cfg = 1;
      n = 0;
      while (inst_valid !== 1'b1 && n < 20) begin tick(1); n++; end
      lat_cfg = 8;
      tick(1);
      checks++;
      if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_pre: inst_valid %b req_valid %b, required 1 0", inst_valid, imem_req_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: req %b valid %b inst %h pc %h, required 0 0 0 0", imem_req_valid, inst_valid, inst, inst_pc);
      end
      tick(1);
      acc_q.delete();
      pop_q.delete();
      lat_cfg = 1;
      rst_n = 1'b1;
      n = 0;
      while (acc_q.size() == 0 && n < 20) begin tick(1); n++; end
      checks++;
      if (acc_q.size() == 0 || acc_q[0] !== RESET_PC) begin errors++; $display("FAIL mid_restart_addr: accepts %0d, required first at %h", acc_q.size(), RESET_PC); end
      inst_ready = 1'b1;
      n = 0;
      while (pop_q.size() == 0 && n < 20) begin tick(1); n++; end
      checks++;
      if (pop_q.size() == 0 || pop_q[0] !== RESET_PC) begin errors++; $display("FAIL mid_restart_pop: pops %0d, required first at %h", pop_q.size(), RESET_PC); end
   endtask

   task automatic test_random();
      int p0;
      do_reset();
      ready_mode = 1;
      lat_cfg = 0;
      p0 = pops;
      for (int c = 0; c < 3000; c++) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
         end else redirect_valid = 1'b0;
         tick(1);
      end
      redirect_valid = 1'b0;
      inst_ready = 1'b1;
      tick(10);
      checks++;
      if (pops - p0 < 100) begin errors++; $display("FAIL random_progress: %0d pops, required at least 100", pops - p0); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_fifo_full();
      test_back_to_back();
      test_redirect_wait();
      test_redirect_handshake();
      test_stall_wrap();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
